// File: rtl/regfile_2r1w.sv
// regfile_2r1w: general-purpose register file, two registered read ports, one write port,
// plus a pending-write scoreboard for issue-stage hazard detection.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data        write port (one write per cycle)
//   rd_enN, rd_addrN -> rd_dataN   read ports, one-cycle latency, same-cycle write forwarding
//   rsv_en, rsv_addr               mark a register as awaiting writeback
//   busy1, busy2                   combinational: read address pending and not written now
//   pend_cnt                       registered number of pending registers
module regfile_2r1w #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned   Depth  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

  logic wr_do;
  logic rsv_do;
  logic clr_fall;
  logic set_rise;

  // Register 0 swallows writes and reservations when hardwired to zero.
  always_comb begin
    wr_do  = wr_en  && !((ZERO_REG != 0) && (wr_addr == '0));
    rsv_do = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
  end

  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0)) begin
      return '0;
    end else if (wr_en && (wr_addr == addr)) begin
      return wr_data;
    end else begin
      return mem_q[addr];
    end
  endfunction

  always_comb begin
    rd_data1_d = rd_en1 ? read_val(rd_addr1) : rd_data1_q;
    rd_data2_d = rd_en2 ? read_val(rd_addr2) : rd_data2_q;
  end

  // Scoreboard: clear on writeback first, then a reservation re-sets (set wins).
  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[wr_addr] = 1'b0;
    end
    if (rsv_do) begin
      pending_d[rsv_addr] = 1'b1;
    end
  end

  // Count follows real bit transitions: a falling bit only when the write clears a set bit that
  // is not immediately re-reserved, a rising bit only when a clear bit is reserved. The two
  // cannot both target the same index, so the net step is always -1, 0 or +1.
  always_comb begin
    clr_fall   = wr_en && pending_q[wr_addr] && !(rsv_do && (rsv_addr == wr_addr));
    set_rise   = rsv_do && !pending_q[rsv_addr];
    pend_cnt_d = pend_cnt_q;
    if (clr_fall && !set_rise) begin
      pend_cnt_d = pend_cnt_q - CntOne;
    end else if (set_rise && !clr_fall) begin
      pend_cnt_d = pend_cnt_q + CntOne;
    end
  end

  always_comb begin
    busy1 = pending_q[rd_addr1] && !(wr_en && (wr_addr == rd_addr1));
    busy2 = pending_q[rd_addr2] && !(wr_en && (wr_addr == rd_addr2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_do) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      pend_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en1 = 1'b0;
  logic [4:0]  rd_addr1 = '0;
  logic [31:0] rd_data1;
  logic        rd_en2 = 1'b0;
  logic [4:0]  rd_addr2 = '0;
  logic [31:0] rd_data2;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        busy1;
  logic        busy2;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  regfile_2r1w #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .ZERO_REG(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en1  (rd_en1),
    .rd_addr1(rd_addr1),
    .rd_data1(rd_data1),
    .rd_en2  (rd_en2),
    .rd_addr2(rd_addr2),
    .rd_data2(rd_data2),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .busy1   (busy1),
    .busy2   (busy2),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays updated from the rules of the register file.
  logic [31:0] mdl_mem [32];
  logic [31:0] mdl_pend;
  logic [31:0] mdl_rd1;
  logic [31:0] mdl_rd2;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return mdl_mem[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_mem[i] <= 32'd0;
      mdl_pend <= 32'd0;
      mdl_rd1  <= 32'd0;
      mdl_rd2  <= 32'd0;
    end else begin
      if (wr_en && wr_addr != 5'd0) mdl_mem[wr_addr] <= wr_data;
      if (rd_en1) mdl_rd1 <= exp_read(rd_addr1);
      if (rd_en2) mdl_rd2 <= exp_read(rd_addr2);
      if (wr_en) mdl_pend[wr_addr] <= 1'b0;
      if (rsv_en && rsv_addr != 5'd0) mdl_pend[rsv_addr] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data1", rd_data1, mdl_rd1);
      check("rd_data2", rd_data2, mdl_rd2);
      check("pend_cnt", {26'd0, pend_cnt}, 32'($countones(mdl_pend)));
      check("busy1", {31'd0, busy1},
            {31'd0, mdl_pend[rd_addr1] && !(wr_en && wr_addr == rd_addr1)});
      check("busy2", {31'd0, busy2},
            {31'd0, mdl_pend[rd_addr2] && !(wr_en && wr_addr == rd_addr2)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rd_en1 = 1'b0;
    rd_en2 = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_pend_cnt", {26'd0, pend_cnt}, 32'd0);
    check("reset_rd1", rd_data1, 32'd0);

    // Write then read back, then hold.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle(); rd_en1 = 1'b1; rd_addr1 = 5'd5;
    tick();
    check("wr_rd_r5", rd_data1, 32'hDEADBEEF);
    idle(); rd_addr1 = 5'd9;
    tick(); tick();
    check("hold_r5", rd_data1, 32'hDEADBEEF);

    // Forwarding on both ports, then zero register.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    rd_en1 = 1'b1; rd_addr1 = 5'd7; rd_en2 = 1'b1; rd_addr2 = 5'd7;
    tick();
    check("fwd_p1", rd_data1, 32'h12345678);
    check("fwd_p2", rd_data2, 32'h12345678);
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    idle(); rd_en1 = 1'b1; rd_addr1 = 5'd0;
    tick();
    check("zero_reg", rd_data1, 32'd0);

    // Reserve r3, then write it back.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idle(); rd_addr1 = 5'd3;
    #1;
    check("busy_r3", {31'd0, busy1}, 32'd1);
    check("cnt_r3", {26'd0, pend_cnt}, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    #1;
    check("busy_r3_wr", {31'd0, busy1}, 32'd0);
    tick();
    check("cnt_r3_clr", {26'd0, pend_cnt}, 32'd0);

    // Reserve + write on r9 while pending, then while not pending.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    wr_en = 1'b1; wr_addr = 5'd9;
    tick();
    check("r9_both_pend", {26'd0, pend_cnt}, 32'd1);
    idle(); rd_addr1 = 5'd9;
    #1;
    check("r9_still_busy", {31'd0, busy1}, 32'd1);
    wr_en = 1'b1; wr_addr = 5'd9;
    tick();
    check("r9_cleared", {26'd0, pend_cnt}, 32'd0);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    check("r9_both_clear", {26'd0, pend_cnt}, 32'd1);
    idle(); wr_en = 1'b1; wr_addr = 5'd9;
    tick();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr1 = 5'd0;
    tick();
    rsv_en = 1'b0;
    check("rsv_r0_cnt", {26'd0, pend_cnt}, 32'd0);
    check("rsv_r0_busy", {31'd0, busy1}, 32'd0);

    // Fill the scoreboard, then reset mid-cycle.
    for (int i = 1; i < 32; i++) begin
      rsv_en = 1'b1; rsv_addr = 5'(i);
      tick();
    end
    rsv_en = 1'b0; rd_addr1 = 5'd3; rd_addr2 = 5'd31;
    check("fill_cnt", {26'd0, pend_cnt}, 32'd31);
    #1;
    check("fill_busy2", {31'd0, busy2}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_cnt", {26'd0, pend_cnt}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    check("rst_rd1", rd_data1, 32'd0);
    check("rst_rd2", rd_data2, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_en1 = 1'b1; rd_addr1 = 5'(i); rd_en2 = 1'b1; rd_addr2 = 5'(31 - i);
      tick();
      check("post_rst_rd1", rd_data1, 32'd0);
      check("post_rst_rd2", rd_data2, 32'd0);
    end

    // Randomized traffic, addresses biased low to provoke hazards and collisions.
    for (int n = 0; n < 3000; n++) begin
      wr_en    = ($urandom_range(0, 1) == 0);
      wr_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      rd_en1   = ($urandom_range(0, 3) != 0);
      rd_addr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rd_en2   = ($urandom_range(0, 3) != 0);
      rd_addr2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rsv_en   = ($urandom_range(0, 4) < 2);
      rsv_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    idle();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
